// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Pulls words out of an upstream FIFO whose read data appears one cycle
//   after the read is accepted. The words go into a 2-entry skid buffer and
//   are presented on a valid/ready stream in FIFO order.
//
// Optional feature macro: STREAM_LAST_EN
//   When it is defined, the block adds a packet counter and the m_last output,
//   which marks every PKT_LEN-th word.
//
// Ports
//   clk, rst_n      clock and asynchronous active-low reset
//   fifo_empty      upstream FIFO empty flag
//   fifo_data_out   upstream read data, valid one cycle after an accepted read
//   fifo_underflow  upstream underflow flag
//   fifo_rd_en      read request to the upstream FIFO
//   m_data/m_valid  stream output; m_ready is the downstream accept
//   m_last          last word of a packet (STREAM_LAST_EN only)
//   word_cnt        16-bit count of stream transfers, wraps
//   underflow_err   sticky underflow flag, cleared only by reset
`timescale 1ns/1ps
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
`ifdef STREAM_LAST_EN
  output logic                  m_last,
`endif
  output logic [15:0]           word_cnt,
  output logic                  underflow_err
);

  logic [1:0]                 occ_q, occ_d;
  logic                       inflight_q;
  logic [1:0][FIFO_WIDTH-1:0] buf_q, buf_d;
  logic [15:0]                word_cnt_q;
  logic                       uf_q;
  logic                       pop, push;
  logic [2:0]                 room_sum;
  logic [1:0]                 wr_idx;

  assign m_valid       = (occ_q != 2'd0);
  assign m_data        = buf_q[0];
  assign word_cnt      = word_cnt_q;
  assign underflow_err = uf_q;

  always_comb begin
    pop  = m_valid && m_ready;
    push = inflight_q;
    // Occupancy left after this cycle's pop, plus one slot held for the
    // word that is already in flight. A new read may issue only while that
    // total is below 2, so a landing word always finds a free slot.
    // m_ready reaches fifo_rd_en combinationally, which lets the block
    // sustain one word per cycle.
    room_sum   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en = rst_n && !fifo_empty && (room_sum < 3'd2);

    buf_d = buf_q;
    if (pop) buf_d[0] = buf_q[1];
    // The landing word goes behind whatever entry survives the pop.
    wr_idx = occ_q - {1'b0, pop};
    if (push) buf_d[wr_idx[0]] = fifo_data_out;
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      buf_q      <= '0;
      word_cnt_q <= '0;
      uf_q       <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      buf_q      <= buf_d;
      word_cnt_q <= word_cnt_q + {15'd0, pop};
      uf_q       <= uf_q | fifo_underflow;
    end
  end

`ifdef STREAM_LAST_EN
  localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  logic [PW-1:0] pkt_cnt_q;

  // The counter holds the packet index of the head word. That index moves
  // only on a transfer, so m_last stays stable while the stream is stalled.
  assign m_last = m_valid && (pkt_cnt_q == PW'(PKT_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pkt_cnt_q <= '0;
    else if (pop)
      pkt_cnt_q <= (pkt_cnt_q == PW'(PKT_LEN - 1)) ? '0 : pkt_cnt_q + PW'(1);
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
`timescale 1ns/1ps
module tb_fifo_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        fifo_empty;
  logic [15:0] fifo_data_out;
  logic        fifo_underflow;
  logic        fifo_rd_en;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] word_cnt;
  logic        underflow_err;
`ifdef STREAM_LAST_EN
  logic        m_last;
`endif

  fifo_stream_reader #(.FIFO_WIDTH(16), .PKT_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_underflow(fifo_underflow),
    .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready),
`ifdef STREAM_LAST_EN
    .m_last(m_last),
`endif
    .word_cnt(word_cnt), .underflow_err(underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream FIFO model: read data is registered, so it appears one cycle
  // after the read is accepted. src_inf turns it into an endless source.
  logic [15:0] mem [0:63];
  logic [31:0] wr_ptr = 0;
  logic [31:0] rd_ptr = 0;
  logic        src_inf = 1'b0;
  logic [15:0] inf_v = 16'h0;

  assign fifo_empty = src_inf ? 1'b0 : (wr_ptr == rd_ptr);

  initial fifo_data_out = 16'h0;
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      if (src_inf) begin
        fifo_data_out <= inf_v;
        inf_v <= inf_v + 16'd1;
      end else begin
        fifo_data_out <= mem[rd_ptr[5:0]];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  // Monitor: sampled on the falling edge, so it records the transfer that
  // happens on the next rising edge.
  int          cyc = 0;
  int          xfer_n = 0;
  int          rd_n = 0;
  int          viol = 0;
  logic [15:0] rec [0:1023];
  int          rec_cyc [0:1023];
  logic        rec_last [0:1023];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fifo_rd_en && fifo_empty) viol = viol + 1;
    if (fifo_rd_en && !fifo_empty) rd_n = rd_n + 1;
    if (m_valid && m_ready) begin
      if (xfer_n < 1024) begin
        rec[xfer_n] = m_data;
        rec_cyc[xfer_n] = cyc;
`ifdef STREAM_LAST_EN
        rec_last[xfer_n] = m_last;
`else
        rec_last[xfer_n] = 1'b0;
`endif
      end
      xfer_n = xfer_n + 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
    n_checks++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL reset_m_data got %h want 0000", m_data); end
    n_checks++; if (word_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_word_cnt got %h want 0000", word_cnt); end
    n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_underflow_err got %0b want 0", underflow_err); end
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %0b want 0", fifo_rd_en); end
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_stream;
    int base;
    base = xfer_n;
    m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) push(16'(i));
    tick(10);
    n_checks++; if (xfer_n - base !== 5) begin n_fail++; $display("FAIL stream_count got %0d want 5", xfer_n - base); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rec[base+i] !== 16'(i+1)) begin n_fail++; $display("FAIL stream_data[%0d] got %h want %h", i, rec[base+i], 16'(i+1)); end
    end
    for (int i = 1; i < 5; i++) begin
      n_checks++; if (rec_cyc[base+i] !== rec_cyc[base] + i) begin n_fail++; $display("FAIL stream_rate[%0d] got cycle %0d want %0d", i, rec_cyc[base+i], rec_cyc[base] + i); end
    end
    n_checks++; if (word_cnt !== 16'd5) begin n_fail++; $display("FAIL stream_word_cnt got %0d want 5", word_cnt); end
    n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL stream_underflow_err got %0b want 0", underflow_err); end
  endtask

  task automatic test_latency;
    m_ready = 1'b1;
    push(16'hA5A5);
    @(negedge clk);
    n_checks++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL lat_rd_en got %0b want 1", fifo_rd_en); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL lat_valid_c0 got %0b want 0", m_valid); end
    tick(1);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL lat_valid_c1 got %0b want 0", m_valid); end
    tick(1);
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid_c2 got %0b want 1", m_valid); end
    n_checks++; if (m_data !== 16'hA5A5) begin n_fail++; $display("FAIL lat_data got %h want a5a5", m_data); end
    tick(2);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL lat_drain got %0b want 0", m_valid); end
    n_checks++; if (word_cnt !== 16'd6) begin n_fail++; $display("FAIL lat_word_cnt got %0d want 6", word_cnt); end
  endtask

  task automatic test_backpressure;
    int base, rbase;
    m_ready = 1'b0;
    rbase = rd_n;
    base = xfer_n;
    for (int i = 0; i < 8; i++) push(16'h0010 + 16'(i));
    tick(3);
    for (int i = 0; i < 7; i++) begin
      n_checks++; if (m_valid !== 1'b1 || m_data !== 16'h0010) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%0b d=%h want v=1 d=0010", i, m_valid, m_data); end
      tick(1);
    end
    n_checks++; if (rd_n - rbase !== 2) begin n_fail++; $display("FAIL bp_reads got %0d want 2", rd_n - rbase); end
    m_ready = 1'b1;
    tick(12);
    n_checks++; if (xfer_n - base !== 8) begin n_fail++; $display("FAIL bp_count got %0d want 8", xfer_n - base); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (rec[base+i] !== 16'h0010 + 16'(i)) begin n_fail++; $display("FAIL bp_data[%0d] got %h want %h", i, rec[base+i], 16'h0010 + 16'(i)); end
    end
  endtask

  task automatic test_toggle;
    int base;
    base = xfer_n;
    for (int i = 0; i < 3; i++) push(16'h0020 + 16'(i));
    for (int i = 0; i < 24; i++) begin
      m_ready = (i % 2 == 0);
      if (i == 10) begin
        n_checks++; if (fifo_empty !== 1'b1 || fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL tog_empty_gate got empty=%0b rd=%0b want 1/0", fifo_empty, fifo_rd_en); end
        push(16'h0023);
        push(16'h0024);
      end
      tick(1);
    end
    n_checks++; if (xfer_n - base !== 5) begin n_fail++; $display("FAIL tog_count got %0d want 5", xfer_n - base); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rec[base+i] !== 16'h0020 + 16'(i)) begin n_fail++; $display("FAIL tog_data[%0d] got %h want %h", i, rec[base+i], 16'h0020 + 16'(i)); end
    end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL tog_drained got %0b want 0", m_valid); end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL rd_on_empty got %0d want 0", viol); end
  endtask

  task automatic test_underflow;
    fifo_underflow = 1'b1;
    @(negedge clk);
    n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL uf_before got %0b want 0", underflow_err); end
    tick(1);
    fifo_underflow = 1'b0;
    n_checks++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL uf_set got %0b want 1", underflow_err); end
    tick(5);
    n_checks++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL uf_sticky got %0b want 1", underflow_err); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL uf_reset got %0b want 0", underflow_err); end
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_mid_reset;
    int base;
    m_ready = 1'b1;
    push(16'h002F);
    tick(4);
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h0030 + 16'(i));
    tick(3);
    n_checks++; if (m_valid !== 1'b1 || word_cnt !== 16'd1) begin n_fail++; $display("FAIL mr_pre got v=%0b cnt=%0d want 1/1", m_valid, word_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mr_valid got %0b want 0", m_valid); end
    n_checks++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL mr_data got %h want 0000", m_data); end
    n_checks++; if (word_cnt !== 16'h0) begin n_fail++; $display("FAIL mr_word_cnt got %0d want 0", word_cnt); end
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL mr_rd_en got %0b want 0", fifo_rd_en); end
    tick(2);
    base = xfer_n;
    m_ready = 1'b1;
    rst_n = 1'b1;
    tick(8);
    n_checks++; if (xfer_n - base !== 2) begin n_fail++; $display("FAIL mr_count got %0d want 2", xfer_n - base); end
    n_checks++; if (rec[base] !== 16'h0032) begin n_fail++; $display("FAIL mr_first got %h want 0032", rec[base]); end
    n_checks++; if (rec[base+1] !== 16'h0033) begin n_fail++; $display("FAIL mr_second got %h want 0033", rec[base+1]); end
  endtask

`ifdef STREAM_LAST_EN
  task automatic test_last;
    int base;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    base = xfer_n;
    m_ready = 1'b1;
    for (int i = 0; i < 9; i++) push(16'h0040 + 16'(i));
    tick(14);
    n_checks++; if (xfer_n - base !== 9) begin n_fail++; $display("FAIL last_count got %0d want 9", xfer_n - base); end
    for (int i = 0; i < 9; i++) begin
      n_checks++; if (rec_last[base+i] !== (i == 3 || i == 7)) begin n_fail++; $display("FAIL last_flag[%0d] got %0b want %0b", i, rec_last[base+i], (i == 3 || i == 7)); end
    end
  endtask
`endif

  task automatic test_wrap;
    int base;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    base = xfer_n;
    src_inf = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      tick(1);
      if (xfer_n - base == 65535) break;
    end
    m_ready = 1'b0;
    src_inf = 1'b0;
    n_checks++; if (word_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff got %h want ffff", word_cnt); end
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    n_checks++; if (word_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got %h want 0000", word_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    m_ready = 1'b0;
    fifo_underflow = 1'b0;
    tick(1);
    test_reset();
    test_stream();
    test_latency();
    test_backpressure();
    test_toggle();
    test_underflow();
    test_mid_reset();
`ifdef STREAM_LAST_EN
    test_last();
`endif
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
